// File: rtl/amm_mem_arbiter_if.sv
// One Avalon-MM link: command signals from the master, stall and read-response signals back.
interface amm_mem_arbiter_if #(
    parameter int ADDR_W  = 31,
    parameter int DATA_W  = 512,
    parameter int BURST_W = 11
);
    localparam int BE_W = DATA_W / 8;

    logic [ADDR_W-1:0]  address;
    logic               read;
    logic               write;
    logic [DATA_W-1:0]  writedata;
    logic [BURST_W-1:0] burstcount;
    logic [BE_W-1:0]    byteenable;
    logic               waitrequest;
    logic               readdatavalid;
    logic [DATA_W-1:0]  readdata;

    modport master (
        output address, read, write, writedata, burstcount, byteenable,
        input  waitrequest, readdatavalid, readdata
    );

    modport slave (
        input  address, read, write, writedata, burstcount, byteenable,
        output waitrequest, readdatavalid, readdata
    );
endinterface

// File: rtl/amm_mem_arbiter.sv
// Two-master Avalon-MM arbiter: round-robin, write bursts hold the grant,
// read beats routed back to the issuing master through an in-order tag FIFO.
module amm_mem_arbiter #(
    parameter int ADDR_W        = 31,
    parameter int DATA_W        = 512,
    parameter int BURST_W       = 11,
    parameter int RD_FIFO_DEPTH = 8
) (
    input  logic                    clk_mem_i,
    input  logic                    rst_mem_i,
    amm_mem_arbiter_if.slave        m0,
    amm_mem_arbiter_if.slave        m1,
    amm_mem_arbiter_if.master       mem,
    output logic                    rsp_err_o
);
    localparam int PTR_W = $clog2(RD_FIFO_DEPTH);

    typedef enum logic {IDLE, WR_BURST} state_t;

    state_t state, state_next;

    logic               last_grant;
    logic               lock_id;
    logic               held_valid;
    logic               held_id;
    logic [BURST_W-1:0] beat_cnt;
    logic [BURST_W-1:0] rsp_cnt;

    logic               tag_id  [RD_FIFO_DEPTH];
    logic [BURST_W-1:0] tag_len [RD_FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;

    logic               fifo_full, fifo_empty;
    logic               req0, req1;
    logic               grant_valid, grant_id;
    logic               sel_read, sel_write;
    logic [BURST_W-1:0] sel_burst, eff_len;
    logic               gnt_wait;
    logic               accept, push, pop;
    logic               head_id;
    logic [BURST_W-1:0] head_len;
    logic               rsp_hit, rsp_last;

    assign fifo_full  = (count == (PTR_W+1)'(RD_FIFO_DEPTH));
    assign fifo_empty = (count == '0);

    // Reads are not eligible while every tag slot is in use; writes always are.
    assign req0 = (m0.read & ~fifo_full) | m0.write;
    assign req1 = (m1.read & ~fifo_full) | m1.write;

    // A stalled grant is kept until its command is accepted, so a late
    // request from the other master cannot steal it.
    always_comb begin
        state_next  = state;
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (!rst_mem_i) begin
            case (state)
                IDLE: begin
                    if (held_valid && (held_id ? req1 : req0)) begin
                        grant_valid = 1'b1;
                        grant_id    = held_id;
                    end else if (req0 && req1) begin
                        grant_valid = 1'b1;
                        grant_id    = ~last_grant;
                    end else if (req0 || req1) begin
                        grant_valid = 1'b1;
                        grant_id    = req1;
                    end
                    if (accept && mem.write && eff_len > BURST_W'(1))
                        state_next = WR_BURST;
                end
                WR_BURST: begin
                    grant_valid = 1'b1;
                    grant_id    = lock_id;
                    if (accept && beat_cnt == BURST_W'(1))
                        state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        sel_read         = grant_id ? m1.read       : m0.read;
        sel_write        = grant_id ? m1.write      : m0.write;
        sel_burst        = grant_id ? m1.burstcount : m0.burstcount;
        eff_len          = (sel_burst == '0) ? BURST_W'(1) : sel_burst;
        mem.address      = grant_id ? m1.address    : m0.address;
        mem.writedata    = grant_id ? m1.writedata  : m0.writedata;
        mem.byteenable   = grant_id ? m1.byteenable : m0.byteenable;
        mem.burstcount   = sel_burst;
        mem.read         = grant_valid & (state == IDLE) & sel_read & ~fifo_full;
        mem.write        = grant_valid & sel_write;
        gnt_wait         = (state == WR_BURST) ? (mem.waitrequest | ~sel_write) : mem.waitrequest;
        m0.waitrequest   = ~(grant_valid & ~grant_id) | gnt_wait;
        m1.waitrequest   = ~(grant_valid &  grant_id) | gnt_wait;
        accept           = (mem.read | mem.write) & ~mem.waitrequest;
        push             = accept & mem.read;
    end

    // Response routing: the FIFO head names the master owning the current read burst.
    assign head_id  = tag_id[rd_ptr];
    assign head_len = tag_len[rd_ptr];
    assign rsp_hit  = mem.readdatavalid & ~fifo_empty & ~rst_mem_i;
    assign rsp_last = ((rsp_cnt + BURST_W'(1)) == head_len);
    assign pop      = rsp_hit & rsp_last;

    assign m0.readdatavalid = rsp_hit & ~head_id;
    assign m1.readdatavalid = rsp_hit &  head_id;
    assign m0.readdata      = mem.readdata;
    assign m1.readdata      = mem.readdata;

    always_ff @(posedge clk_mem_i) begin
        if (rst_mem_i) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            lock_id    <= 1'b0;
            held_valid <= 1'b0;
            held_id    <= 1'b0;
            beat_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rsp_cnt    <= '0;
            rsp_err_o  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                last_grant <= grant_id;
                held_valid <= 1'b0;
            end else if (grant_valid && state == IDLE) begin
                held_valid <= 1'b1;
                held_id    <= grant_id;
            end
            if (state == IDLE && accept && mem.write && eff_len > BURST_W'(1)) begin
                beat_cnt <= eff_len - BURST_W'(1);
                lock_id  <= grant_id;
            end else if (state == WR_BURST && accept) begin
                beat_cnt <= beat_cnt - BURST_W'(1);
            end
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            if (rsp_hit)
                rsp_cnt <= rsp_last ? '0 : rsp_cnt + BURST_W'(1);
            if (mem.readdatavalid && fifo_empty)
                rsp_err_o <= 1'b1;
        end
    end

    // Tag storage needs no reset: occupancy is governed by count and the pointers.
    always_ff @(posedge clk_mem_i) begin
        if (!rst_mem_i && push) begin
            tag_id[wr_ptr]  <= grant_id;
            tag_len[wr_ptr] <= eff_len;
        end
    end
endmodule

// File: tb/tb_amm_mem_arbiter.sv
// Self-checking bench for amm_mem_arbiter: directed scenarios plus random traffic,
// checked by a grant/command scoreboard and a read-response scoreboard.
module tb_amm_mem_arbiter;
    localparam int ADDR_W  = 31;
    localparam int DATA_W  = 512;
    localparam int BURST_W = 11;
    localparam int DEPTH   = 8;
    localparam int BE_W    = DATA_W / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rsp_err;
    always #5 clk = ~clk;

    amm_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) m0_bus ();
    amm_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) m1_bus ();
    amm_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W)) mem_bus ();

    amm_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .RD_FIFO_DEPTH(DEPTH)) dut (
        .clk_mem_i (clk),
        .rst_mem_i (rst),
        .m0        (m0_bus),
        .m1        (m1_bus),
        .mem       (mem_bus),
        .rsp_err_o (rsp_err)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                len;
        bit                wr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
    } cmd_t;

    typedef struct {
        int id;
        int len;
    } rd_t;

    int checks = 0;
    int fails  = 0;

    cmd_t exp_cmd0[$];
    cmd_t exp_cmd1[$];
    rd_t  out_q[$];
    logic [DATA_W-1:0] beat_q[$];
    int   out_size_pre = 0;

    int  wait_pct    = 0;
    bit  wait_toggle = 1'b0;
    bit  rsp_en      = 1'b1;
    bit  inject_err  = 1'b0;

    function automatic int eff_len(input int n);
        return (n == 0) ? 1 : n;
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s at %0t: got %0h, required %0h", name, $time, act, exp);
        end
    endtask

    task automatic reportFail(input string name, input string what);
        checks++;
        fails++;
        $display("[TB] FAIL %s at %0t: %s", name, $time, what);
    endtask

    // Issues one command (all beats of a write burst) from master id, holding each
    // beat until accepted; gives up if reset is raised.
    task automatic applyStimulus(input int id, input bit wr, input int len, input int gap);
        logic [ADDR_W-1:0] a;
        cmd_t e;
        int beats;
        int t;
        bit stalled;
        a = {id[0], (ADDR_W-1)'($urandom)};
        beats = wr ? eff_len(len) : 1;
        for (int b = 0; b < beats; b++) begin
            if (rst) break;
            e.addr = a; e.len = len; e.wr = wr;
            e.data = rand_data();
            e.be   = {$urandom, $urandom};
            if (id == 0) begin
                exp_cmd0.push_back(e);
                m0_bus.address = a; m0_bus.read = ~wr; m0_bus.write = wr;
                m0_bus.writedata = e.data; m0_bus.byteenable = e.be; m0_bus.burstcount = BURST_W'(len);
            end else begin
                exp_cmd1.push_back(e);
                m1_bus.address = a; m1_bus.read = ~wr; m1_bus.write = wr;
                m1_bus.writedata = e.data; m1_bus.byteenable = e.be; m1_bus.burstcount = BURST_W'(len);
            end
            t = 0;
            forever begin
                @(negedge clk);
                stalled = (id == 0) ? m0_bus.waitrequest : m1_bus.waitrequest;
                if (!stalled || rst) break;
                t++;
                if (t > 2000) begin
                    reportFail("cmd_timeout", $sformatf("master %0d command not accepted within 2000 cycles", id));
                    break;
                end
            end
            @(posedge clk); #1;
        end
        if (id == 0) begin m0_bus.read = 1'b0; m0_bus.write = 1'b0; end
        else         begin m1_bus.read = 1'b0; m1_bus.write = 1'b0; end
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic drainResponses();
        int t = 0;
        while ((out_q.size() > 0 || beat_q.size() > 0) && t < 3000) begin
            @(posedge clk);
            t++;
        end
        #1;
        checkOutput("drain_outstanding", out_q.size(), 0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // Memory responder: random or toggling stall, returns queued read beats in order.
    initial begin
        mem_bus.waitrequest   = 1'b0;
        mem_bus.readdatavalid = 1'b0;
        mem_bus.readdata      = '0;
        forever begin
            @(posedge clk); #1;
            if (wait_toggle) mem_bus.waitrequest = ~mem_bus.waitrequest;
            else             mem_bus.waitrequest = (int'($urandom_range(99)) < wait_pct);
            if (inject_err) begin
                mem_bus.readdatavalid = 1'b1;
                mem_bus.readdata      = rand_data();
                inject_err            = 1'b0;
            end else if (rsp_en && beat_q.size() > 0 && $urandom_range(3) != 0) begin
                mem_bus.readdatavalid = 1'b1;
                mem_bus.readdata      = beat_q.pop_front();
            end else begin
                mem_bus.readdatavalid = 1'b0;
            end
        end
    end

    // Response monitor: pops the oldest outstanding read and checks routing of each beat.
    initial begin : rsp_mon
        bit m_err;
        int got;
        rd_t h;
        m_err = 1'b0;
        got   = 0;
        forever begin
            @(negedge clk);
            out_size_pre = out_q.size();
            if (rst) begin
                out_q.delete();
                m_err = 1'b0;
                got   = 0;
                continue;
            end
            checkOutput("rsp_err", rsp_err, m_err);
            if (mem_bus.readdatavalid) begin
                if (out_q.size() == 0) begin
                    checkOutput("dropped_beat", {m1_bus.readdatavalid, m0_bus.readdatavalid}, 2'b00);
                    m_err = 1'b1;
                end else begin
                    h = out_q[0];
                    checkOutput("rsp_route", {m1_bus.readdatavalid, m0_bus.readdatavalid}, (h.id == 1) ? 2'b10 : 2'b01);
                    checkOutput("rsp_data", (h.id == 1) ? m1_bus.readdata : m0_bus.readdata, mem_bus.readdata);
                    got++;
                    if (got == h.len) begin
                        void'(out_q.pop_front());
                        got = 0;
                    end
                end
            end else begin
                checkOutput("rsp_idle", {m1_bus.readdatavalid, m0_bus.readdatavalid}, 2'b00);
            end
        end
    end

    // Command monitor: round-robin / burst-lock grant model and per-master command scoreboard.
    initial begin : cmd_mon
        int  m_last, own, burst_left, exp_id, len;
        bit  own_v, elig0, elig1, exp_v, exp_strobe, obs_v, have;
        logic w_gnt, w_oth;
        cmd_t e;
        m_last = 1; own = 0; burst_left = 0; own_v = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (rst) begin
                checkOutput("reset_outputs",
                    {mem_bus.read, mem_bus.write, m0_bus.waitrequest, m1_bus.waitrequest,
                     m0_bus.readdatavalid, m1_bus.readdatavalid}, 6'b001100);
                m_last = 1; own_v = 1'b0; burst_left = 0;
                exp_cmd0.delete(); exp_cmd1.delete();
                continue;
            end
            elig0 = m0_bus.write | (m0_bus.read & (out_size_pre < DEPTH));
            elig1 = m1_bus.write | (m1_bus.read & (out_size_pre < DEPTH));
            exp_v = 1'b0; exp_id = 0;
            if (burst_left > 0 || own_v)   begin exp_v = 1'b1; exp_id = own; end
            else if (elig0 && elig1)       begin exp_v = 1'b1; exp_id = 1 - m_last; end
            else if (elig0 || elig1)       begin exp_v = 1'b1; exp_id = elig1 ? 1 : 0; end
            if (burst_left > 0) exp_strobe = (own == 0) ? m0_bus.write : m1_bus.write;
            else                exp_strobe = exp_v;
            obs_v = mem_bus.read | mem_bus.write;
            checkOutput("grant_present", obs_v, exp_strobe);
            if (obs_v && exp_strobe)
                checkOutput("grant_id", mem_bus.address[ADDR_W-1], exp_id);
            if (exp_v) begin
                w_gnt = (exp_id == 0) ? m0_bus.waitrequest : m1_bus.waitrequest;
                w_oth = (exp_id == 0) ? m1_bus.waitrequest : m0_bus.waitrequest;
                checkOutput("wait_other", w_oth, 1'b1);
                if (exp_strobe) checkOutput("wait_granted", w_gnt, mem_bus.waitrequest);
            end else begin
                checkOutput("wait_idle", {m1_bus.waitrequest, m0_bus.waitrequest}, 2'b11);
            end
            if (obs_v && !mem_bus.waitrequest) begin
                have = (exp_id == 0) ? (exp_cmd0.size() > 0) : (exp_cmd1.size() > 0);
                if (!have) begin
                    reportFail("unexpected_cmd", $sformatf("memory accepted a command for master %0d that it never issued", exp_id));
                end else begin
                    if (exp_id == 0) e = exp_cmd0.pop_front();
                    else             e = exp_cmd1.pop_front();
                    checkOutput("cmd_kind", mem_bus.write, e.wr);
                    checkOutput("cmd_addr", mem_bus.address, e.addr);
                    checkOutput("cmd_burst", mem_bus.burstcount, e.len);
                    if (e.wr) begin
                        checkOutput("wr_data", mem_bus.writedata, e.data);
                        checkOutput("wr_be", mem_bus.byteenable, e.be);
                    end
                    len = eff_len(e.len);
                    if (e.wr) begin
                        if (burst_left > 0) burst_left--;
                        else if (len > 1) begin burst_left = len - 1; own = exp_id; end
                    end else begin
                        out_q.push_back('{exp_id, len});
                        for (int k = 0; k < len; k++) beat_q.push_back(rand_data());
                    end
                end
                m_last = exp_id;
                own_v  = 1'b0;
            end else if (exp_v && burst_left == 0) begin
                own_v = 1'b1;
                own   = exp_id;
            end
        end
    end

    initial begin
        int n;
        m0_bus.address = '0; m0_bus.read = 1'b0; m0_bus.write = 1'b0; m0_bus.writedata = '0;
        m0_bus.burstcount = '0; m0_bus.byteenable = '0;
        m1_bus.address = '0; m1_bus.read = 1'b0; m1_bus.write = 1'b0; m1_bus.writedata = '0;
        m1_bus.burstcount = '0; m1_bus.byteenable = '0;

        // Requests held during reset must not reach memory.
        @(posedge clk); #1;
        m0_bus.read = 1'b1; m1_bus.write = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        m0_bus.read = 1'b0; m1_bus.write = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] single master read burst 4");
        applyStimulus(0, 1'b0, 4, 0);
        drainResponses();

        $display("[TB] contention: alternating single reads");
        fork
            repeat (8) applyStimulus(0, 1'b0, 1, 0);
            repeat (8) applyStimulus(1, 1'b0, 1, 0);
        join
        drainResponses();

        $display("[TB] tag FIFO full");
        rsp_en = 1'b0;
        fork
            repeat (9) applyStimulus(0, 1'b0, 2, 0);
            begin
                repeat (20) begin @(posedge clk); #1; end
                applyStimulus(1, 1'b1, 1, 0);
                repeat (10) begin @(posedge clk); #1; end
                rsp_en = 1'b1;
            end
        join
        drainResponses();

        $display("[TB] write burst lock with toggling stall");
        wait_toggle = 1'b1;
        fork
            applyStimulus(1, 1'b1, 8, 0);
            begin
                repeat (2) begin @(posedge clk); #1; end
                applyStimulus(0, 1'b0, 1, 0);
            end
        join
        wait_toggle = 1'b0;
        mem_bus.waitrequest = 1'b0;
        drainResponses();

        $display("[TB] random traffic");
        wait_pct = 30;
        fork
            for (int i = 0; i < 40; i++)
                applyStimulus(0, 1'($urandom_range(1)), int'($urandom_range(5)), int'($urandom_range(3)));
            for (int i = 0; i < 40; i++)
                applyStimulus(1, 1'($urandom_range(1)), int'($urandom_range(5)), int'($urandom_range(3)));
        join
        wait_pct = 0;
        drainResponses();

        $display("[TB] unexpected readdatavalid");
        inject_err = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        @(negedge clk);
        checkOutput("err_sticky", rsp_err, 1'b1);
        @(posedge clk); #1;

        $display("[TB] reset in the middle of a write burst");
        fork
            applyStimulus(1, 1'b1, 8, 0);
            begin
                n = 0;
                for (int t = 0; t < 200 && n < 3; t++) begin
                    @(negedge clk);
                    if (m1_bus.write && !m1_bus.waitrequest) n++;
                end
                checkOutput("beats_before_reset", n, 3);
                @(posedge clk); #1;
                rst = 1'b1;
                repeat (3) begin @(posedge clk); #1; end
                rst = 1'b0;
            end
        join
        @(posedge clk); #1;
        fork
            applyStimulus(0, 1'b0, 1, 0);
            applyStimulus(1, 1'b0, 1, 0);
        join
        drainResponses();

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end
endmodule
